// File: rtl/fifo_pkg.sv
// Shared constants, types and the pointer-difference helper for the circular FIFO.
package fifo_pkg;

    localparam int LARGURA_PADRAO      = 8;
    localparam int PROFUNDIDADE_PADRAO = 8;

    typedef logic [7:0] byte_t;

    // Occupancy is the pointer difference modulo 2^(aw+1). The wrap bit makes
    // the full and empty cases distinct without a separate counter.
    function automatic logic [31:0] ocupacao_ptr(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int          aw
    );
        logic [31:0] mascara;
        mascara = (32'd1 << (aw + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mascara;
    endfunction

endpackage

// File: rtl/fifo_circular_memoria_fila.sv
// Storage array for the circular FIFO: synchronous write, synchronous read, no reset.
module memoria_fila
    import fifo_pkg::*;
#(
    parameter  int LARGURA      = LARGURA_PADRAO,
    parameter  int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    localparam int AW           = $clog2(PROFUNDIDADE)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [LARGURA-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [LARGURA-1:0] rdata
);

    logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
    logic [LARGURA-1:0] r_rdata;

    // Write port. When the FIFO is full the read and write share an address;
    // the non-blocking update means the read below still returns the old byte.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; rdata holds its value when re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/fifo_circular.sv
// Circular-buffer FIFO behind the byte delay line: pointer control, status and sticky error flags.
module fifo_circular
    import fifo_pkg::*;
#(
    parameter  int LARGURA      = LARGURA_PADRAO,
    parameter  int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    localparam int AW           = $clog2(PROFUNDIDADE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               escrever,
    input  logic [LARGURA-1:0] data_ent,
    input  logic               ler,
    output logic [LARGURA-1:0] data_sai,
    output logic               valido_sai,
    output logic               fila_cheia,
    output logic               fila_vazia,
    output logic [AW:0]        ocupacao,
    output logic               erro_estouro,
    output logic               erro_vazio
);

    // Pointers carry one extra wrap bit beyond the address.
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               r_lido;
    logic [LARGURA-1:0] r_data_hold;
    logic               r_erro_estouro;
    logic               r_erro_vazio;

    logic               w_vazia;
    logic               w_cheia;
    logic               w_ler_ok;
    logic               w_esc_ok;
    logic               w_mem_we;
    logic               w_mem_re;
    logic [LARGURA-1:0] w_rdata;

    // Status comes only from registered pointers, never from this cycle's requests.
    always_comb begin
        w_vazia = (r_wr_ptr == r_rd_ptr);
        w_cheia = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
    end

    // Request acceptance. A write while full is allowed only when a read frees
    // the head slot in the same cycle; an empty FIFO never bypasses to the reader.
    always_comb begin
        w_ler_ok = ler && !w_vazia;
        w_esc_ok = escrever && (!w_cheia || w_ler_ok);
        w_mem_we = w_esc_ok && !rst;
        w_mem_re = w_ler_ok && !rst;
    end

    memoria_fila #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_memoria (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (data_ent),
        .re    (w_mem_re),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

    // Write and read pointers; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_esc_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ler_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Read-valid tracking plus a hold copy of the last popped byte, so data_sai
    // reads 0 after reset even though the storage array is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lido      <= 1'b0;
            r_data_hold <= '0;
        end else begin
            r_lido <= w_ler_ok;
            if (r_lido) begin
                r_data_hold <= w_rdata;
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_erro_estouro <= 1'b0;
            r_erro_vazio   <= 1'b0;
        end else begin
            if (escrever && w_cheia && !w_ler_ok) begin
                r_erro_estouro <= 1'b1;
            end
            if (ler && w_vazia) begin
                r_erro_vazio <= 1'b1;
            end
        end
    end

    assign data_sai     = r_lido ? w_rdata : r_data_hold;
    assign valido_sai   = r_lido;
    assign fila_cheia   = w_cheia;
    assign fila_vazia   = w_vazia;
    assign ocupacao     = (AW + 1)'(ocupacao_ptr(32'(r_wr_ptr), 32'(r_rd_ptr), AW));
    assign erro_estouro = r_erro_estouro;
    assign erro_vazio   = r_erro_vazio;

endmodule

// File: tb/tb_fifo_circular.sv
// Directed bench for fifo_circular with hand-computed expectations.
module tb_fifo_circular;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       escrever;
    logic [7:0] data_ent;
    logic       ler;
    logic [7:0] data_sai;
    logic       valido_sai;
    logic       fila_cheia;
    logic       fila_vazia;
    logic [3:0] ocupacao;
    logic       erro_estouro;
    logic       erro_vazio;

    int n_comp  = 0;
    int n_falha = 0;

    fifo_circular #(.LARGURA(8), .PROFUNDIDADE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .escrever     (escrever),
        .data_ent     (data_ent),
        .ler          (ler),
        .data_sai     (data_sai),
        .valido_sai   (valido_sai),
        .fila_cheia   (fila_cheia),
        .fila_vazia   (fila_vazia),
        .ocupacao     (ocupacao),
        .erro_estouro (erro_estouro),
        .erro_vazio   (erro_vazio)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_falha++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic ciclo(input logic r, input logic esc, input logic [7:0] d, input logic le);
        @(negedge clk);
        rst      = r;
        escrever = esc;
        data_ent = d;
        ler      = le;
        @(posedge clk);
        #1;
    endtask

    task automatic verifica_reset(input string tag);
        verifica({tag, "_vazia"},   32'(fila_vazia),   32'd1);
        verifica({tag, "_cheia"},   32'(fila_cheia),   32'd0);
        verifica({tag, "_ocup"},    32'(ocupacao),     32'd0);
        verifica({tag, "_valido"},  32'(valido_sai),   32'd0);
        verifica({tag, "_data"},    32'(data_sai),     32'd0);
        verifica({tag, "_estouro"}, 32'(erro_estouro), 32'd0);
        verifica({tag, "_evazio"},  32'(erro_vazio),   32'd0);
    endtask

    byte_t q[$];
    byte_t esperado;
    byte_t dreno [8] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hBB};

    initial begin
        rst = 1'b1; escrever = 1'b0; data_ent = 8'h00; ler = 1'b0;

        // Reset then idle
        ciclo(1'b1, 1'b0, 8'h00, 1'b0);
        ciclo(1'b1, 1'b0, 8'h00, 1'b0);
        ciclo(1'b0, 1'b0, 8'h00, 1'b0);
        verifica_reset("reset");

        // Fill with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            ciclo(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
            verifica("fill_ocup", 32'(ocupacao), 32'(i + 1));
        end
        verifica("fill_cheia", 32'(fila_cheia), 32'd1);
        verifica("fill_vazia", 32'(fila_vazia), 32'd0);

        // Drain, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            ciclo(1'b0, 1'b0, 8'h00, 1'b1);
            verifica("drain_data",   32'(data_sai),   32'(8'h11 + i));
            verifica("drain_valido", 32'(valido_sai), 32'd1);
        end
        verifica("drain_vazia", 32'(fila_vazia), 32'd1);
        ciclo(1'b0, 1'b0, 8'h00, 1'b0);
        verifica("idle_valido", 32'(valido_sai), 32'd0);
        verifica("idle_hold",   32'(data_sai),   32'h18);

        // Refill, then overflow with 0xAA
        for (int i = 0; i < 8; i++) ciclo(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
        verifica("refill_cheia", 32'(fila_cheia), 32'd1);
        ciclo(1'b0, 1'b1, 8'hAA, 1'b0);
        verifica("ovf_flag", 32'(erro_estouro), 32'd1);
        verifica("ovf_ocup", 32'(ocupacao),     32'd8);
        verifica("ovf_evazio", 32'(erro_vazio), 32'd0);

        // Full with simultaneous read and write of 0xBB
        ciclo(1'b0, 1'b1, 8'hBB, 1'b1);
        verifica("fullrw_data",   32'(data_sai),   32'h11);
        verifica("fullrw_valido", 32'(valido_sai), 32'd1);
        verifica("fullrw_ocup",   32'(ocupacao),   32'd8);
        verifica("fullrw_cheia",  32'(fila_cheia), 32'd1);
        for (int i = 0; i < 8; i++) begin
            ciclo(1'b0, 1'b0, 8'h00, 1'b1);
            verifica("fullrw_drain", 32'(data_sai), 32'(dreno[i]));
        end
        verifica("fullrw_vazia", 32'(fila_vazia), 32'd1);

        // Empty with simultaneous write 0x5C and read
        ciclo(1'b0, 1'b1, 8'h5C, 1'b1);
        verifica("emptyrw_evazio", 32'(erro_vazio), 32'd1);
        verifica("emptyrw_valido", 32'(valido_sai), 32'd0);
        verifica("emptyrw_ocup",   32'(ocupacao),   32'd1);
        ciclo(1'b0, 1'b0, 8'h00, 1'b1);
        verifica("emptyrw_data",   32'(data_sai),   32'h5C);
        verifica("emptyrw_valido2", 32'(valido_sai), 32'd1);
        verifica("emptyrw_vazia",  32'(fila_vazia), 32'd1);

        // 20 interleaved cycles: write every cycle, read two of every three
        for (int i = 0; i < 20; i++) begin
            logic le;
            le = (i % 3) != 0;
            ciclo(1'b0, 1'b1, 8'(8'h30 + i), le);
            if (le) begin
                esperado = q.pop_front();
                verifica("wrap_data",   32'(data_sai),   32'(esperado));
                verifica("wrap_valido", 32'(valido_sai), 32'd1);
            end
            q.push_back(8'(8'h30 + i));
            verifica("wrap_ocup", 32'(ocupacao), 32'(q.size()));
        end
        // Leave 3 entries stored
        for (int i = 0; i < 4; i++) begin
            ciclo(1'b0, 1'b0, 8'h00, 1'b1);
            esperado = q.pop_front();
            verifica("wrap_drain", 32'(data_sai), 32'(esperado));
        end
        verifica("pre_rst_ocup", 32'(ocupacao), 32'd3);

        // Reset with 3 stored; requests during reset must be ignored
        ciclo(1'b1, 1'b1, 8'hEE, 1'b1);
        verifica_reset("midrst");
        ciclo(1'b0, 1'b1, 8'h77, 1'b0);
        verifica("post_rst_ocup", 32'(ocupacao), 32'd1);
        ciclo(1'b0, 1'b0, 8'h00, 1'b1);
        verifica("post_rst_data",   32'(data_sai),   32'h77);
        verifica("post_rst_valido", 32'(valido_sai), 32'd1);
        verifica("post_rst_vazia",  32'(fila_vazia), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule

// File: doc/fifo_circular.md
Name: fifo_circular

Overview:
- Circular-buffer FIFO that sits directly downstream of the 8-bit shift-register delay line (fifo).
- Captures that stage's byte output, one per cycle when `escrever` is high, and buffers it for a consumer that may stall.
- Gives the consumer read-enable flow control, full/empty/occupancy status and sticky overflow/underflow flags.
- Single clock domain.

Parameters:
- LARGURA, 8, data width in bits.
- PROFUNDIDADE, 8, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(PROFUNDIDADE), address width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- escrever  input  1  write request for data_ent this cycle.
- data_ent  input  LARGURA  write data, driven from the delay line's data_sai.
- ler  input  1  read request (pop head entry).
- data_sai  output  LARGURA  registered read data.
- valido_sai  output  1  data_sai holds a byte popped on the previous cycle.
- fila_cheia  output  1  occupancy == PROFUNDIDADE.
- fila_vazia  output  1  occupancy == 0.
- ocupacao  output  AW+1  number of stored entries, 0..PROFUNDIDADE.
- erro_estouro  output  1  sticky: write attempted while full without a simultaneous read.
- erro_vazio  output  1  sticky: read attempted while empty.

Behaviour:
- Reset, checked at every rising clk with rst=1:
  - Pointers and ocupacao go to 0; data_sai goes to 0.
  - valido_sai=0, erro_estouro=0, erro_vazio=0; fila_vazia=1, fila_cheia=0.
  - Memory contents are not cleared.
  - rst overrides escrever and ler in the same cycle.
  - Reset mid-operation discards all stored data; the first write after reset lands in entry 0.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits; the MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low AW bits are equal and the MSBs differ.
  - Pointers increment modulo 2^(AW+1) and wrap silently.
- Status outputs are combinational from the pointers and reflect state after the last edge; they do not depend on this cycle's requests.
- Write accepted (wr_ok) when escrever=1 and (fila_cheia=0 or ler_ok=1):
  - mem[wr_ptr[AW-1:0]] <= data_ent; wr_ptr increments.
- Read accepted (ler_ok) when ler=1 and fila_vazia=0:
  - data_sai <= mem[rd_ptr[AW-1:0]]; rd_ptr increments; valido_sai <= 1 on the next edge.
- When there is no ler_ok: valido_sai <= 0 and data_sai holds its last value.
- Read latency is 1 cycle from the ler edge to valid data_sai.
- Simultaneous read and write:
  - When full: both are accepted and ocupacao is unchanged. The read returns the old head, never the byte being written.
  - When empty: the write is accepted; the read is rejected, erro_vazio is set and valido_sai=0. No write-to-read bypass.
  - Otherwise: both are accepted and ocupacao is unchanged.
- ocupacao update: +1 on wr_ok only, -1 on ler_ok only, unchanged for both or neither.
- Overflow: escrever=1, fila_cheia=1, ler=0 → data is dropped, state unchanged, erro_estouro <= 1.
- Underflow: ler=1, fila_vazia=1 → erro_vazio <= 1, no pointer change.
- Error flags clear only on rst.
- Invariants:
  - Never fila_cheia && fila_vazia.
  - ocupacao == wr_ptr - rd_ptr (mod 2^(AW+1)).
  - Bytes leave in exactly the order they were accepted.

Decomposition:
- Package fifo_pkg:
  - Constants LARGURA_PADRAO=8 and PROFUNDIDADE_PADRAO=8.
  - typedef byte_t (logic [7:0]).
  - Function for pointer-difference occupancy.
- One sub-module, memoria_fila:
  - Synchronous-write, synchronous-read memory of PROFUNDIDADE x LARGURA.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
  - No reset on the storage array.
- Top-level fifo_circular owns the pointers, flags and control.

Test Plan:
- Reset then idle → fila_vazia=1, fila_cheia=0, ocupacao=0, valido_sai=0, data_sai=0, both error flags 0.
- Write 0x11..0x18 on 8 consecutive cycles, then read 8 cycles → fila_cheia=1 after the 8th write; reads return 0x11..0x18 in order, valido_sai=1 one cycle after each ler; fila_vazia=1 at the end.
- While full, write 0xAA with ler=0 → erro_estouro=1, ocupacao stays 8, 0xAA never appears on data_sai.
- While full, write 0xBB with ler=1 → data_sai=0x11 (old head), ocupacao stays 8, no error. Draining then yields 0x12..0x18 followed by 0xBB.
- Empty, escrever=1 with 0x5C and ler=1 together → erro_vazio=1, valido_sai=0, ocupacao=1. The next read returns 0x5C.
- Wrap and reset:
  - Run 20 interleaved write/read cycles to wrap the pointers twice; order must be preserved throughout.
  - Assert rst with 3 entries stored → ocupacao=0, flags cleared.
  - Then write 0x77 and read → data_sai=0x77.
